// File: rtl/math_result_fifo_if.sv
// Read-side handshake bundle for math_result_fifo: FWFT head data plus valid/ready.
// The FIFO takes the master modport; the bus-side consumer takes the slave modport.
interface math_result_fifo_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/math_result_fifo.sv
// Change-triggered capture FIFO behind the math adder: pushes each new result, FWFT read side.
// Optional overflow counter enabled by defining MATH_RESULT_FIFO_DROP_CNT_EN.
module math_result_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [31:0]         result,
    input  logic [31:0]         statistic,
    math_result_fifo_if.master  rd,
    output logic [31:0]         stat_snap,
    output logic [AW:0]         level,
    output logic                full,
    output logic                empty
`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   result_q, result_d;
    logic [31:0]   stat_snap_q, stat_snap_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    logic push;
    logic pop;
    logic accept;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign stat_snap = stat_snap_q;

    assign rd.dout_valid = !empty;
    assign rd.dout       = empty ? 32'h0 : mem_q[rd_ptr_q];

    assign push = en && (result != result_q);
    assign pop  = rd.dout_valid && rd.dout_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept = push && (!full || pop);

    always_comb begin
        result_d    = result;
        stat_snap_d = stat_snap_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;

        if (accept) begin
            wr_ptr_d    = wr_ptr_q + AW'(1);
            stat_snap_d = statistic;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (pop && !accept) begin
            level_d = level_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q    <= '0;
            stat_snap_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            result_q    <= result_d;
            stat_snap_q <= stat_snap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Storage is deliberately left unreset; empty masks stale words on dout.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push && !accept && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_math_result_fifo.sv
// Randomized self-checking bench for math_result_fifo against a queue-based reference model.
// Directed scenarios first, then a random phase, then an asynchronous reset mid-stream.
module tb_math_result_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] result;
    logic [31:0] statistic;
    logic [31:0] stat_snap;
    logic [AW:0] level;
    logic        full;
    logic        empty;
`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    math_result_fifo_if rd_if ();

    math_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .result    (result),
        .statistic (statistic),
        .rd        (rd_if),
        .stat_snap (stat_snap),
        .level     (level),
        .full      (full),
        .empty     (empty)
`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] modelQ[$];
    logic [31:0] modelPrev;
    logic [31:0] modelStat;
    int          modelDrops;

    // Every comparison in the bench is routed through here so counts stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model wipes to its post-reset state.
    task automatic modelReset();
        modelQ.delete();
        modelPrev  = 32'h0;
        modelStat  = 32'h0;
        modelDrops = 0;
    endtask

    // Compare every observable output with what the model says it should be.
    task automatic compareAll(input string tag);
        logic [31:0] expHead;
        expHead = (modelQ.size() != 0) ? modelQ[0] : 32'h0;
        checkOutput({tag, ".dout"},       rd_if.dout,               expHead);
        checkOutput({tag, ".dout_valid"}, 32'(rd_if.dout_valid),    32'(modelQ.size() != 0));
        checkOutput({tag, ".level"},      32'(level),               32'(modelQ.size()));
        checkOutput({tag, ".full"},       32'(full),                32'(modelQ.size() == DEPTH));
        checkOutput({tag, ".empty"},      32'(empty),               32'(modelQ.size() == 0));
        checkOutput({tag, ".stat_snap"},  stat_snap,                modelStat);
`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
        checkOutput({tag, ".drop_cnt"},   32'(drop_cnt),            32'(modelDrops));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check just after it.
    task automatic applyStimulus(input logic enIn, input logic [31:0] resIn,
                                 input logic [31:0] statIn, input logic readyIn,
                                 input string tag);
        bit doPush;
        bit doPop;
        en               = enIn;
        result           = resIn;
        statistic        = statIn;
        rd_if.dout_ready = readyIn;
        @(posedge clk);
        doPush = enIn && (resIn != modelPrev);
        doPop  = (modelQ.size() != 0) && readyIn;
        if (doPop) modelQ.delete(0);
        if (doPush) begin
            if (modelQ.size() < DEPTH) begin
                modelQ.push_back(resIn);
                modelStat = statIn;
            end else if (modelDrops < 65535) begin
                modelDrops++;
            end
        end
        modelPrev = resIn;
        #1;
        compareAll(tag);
    endtask

    initial begin
        rst              = 1'b0;
        en               = 1'b1;
        result           = 32'h0;
        statistic        = 32'h0;
        rd_if.dout_ready = 1'b0;
        modelReset();

        #3;
        compareAll("reset");
        @(posedge clk);
        #3 rst = 1'b1;

        // Idle with result parked at zero: nothing should ever be pushed.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, "idle");

        applyStimulus(1'b1, 32'd5, 32'hc0010001, 1'b0, "single");
        checkOutput("single.dout_lit", rd_if.dout, 32'd5);
        checkOutput("single.stat_lit", stat_snap, 32'hc0010001);
        applyStimulus(1'b1, 32'd5, 32'h0, 1'b1, "single_pop");
        checkOutput("single_pop.empty_lit", 32'(empty), 32'd1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'd7, 32'h70 + 32'(i), 1'b0, "repeat");
        checkOutput("repeat.level_lit", 32'(level), 32'd1);
        applyStimulus(1'b0, 32'd9, 32'h90, 1'b0, "gated");
        applyStimulus(1'b1, 32'd9, 32'h91, 1'b0, "gated_hold");
        checkOutput("gated.level_lit", 32'(level), 32'd1);
        checkOutput("gated.stat_lit", stat_snap, 32'h70);
        applyStimulus(1'b1, 32'd9, 32'h0, 1'b1, "gated_drain");

        for (int v = 1; v <= 10; v++) applyStimulus(1'b1, 32'(v), 32'h100 + 32'(v), 1'b0, "overflow");
        checkOutput("overflow.full_lit", 32'(full), 32'd1);
        checkOutput("overflow.level_lit", 32'(level), 32'd8);
        checkOutput("overflow.stat_lit", stat_snap, 32'h108);
`ifdef MATH_RESULT_FIFO_DROP_CNT_EN
        checkOutput("overflow.drop_lit", 32'(drop_cnt), 32'd2);
`endif

        applyStimulus(1'b1, 32'd11, 32'h111, 1'b1, "full_pushpop");
        checkOutput("full_pushpop.level_lit", 32'(level), 32'd8);
        checkOutput("full_pushpop.dout_lit", rd_if.dout, 32'd2);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'd11, 32'h0, 1'b1, "drain");
        checkOutput("drain.last_lit", rd_if.dout, 32'd11);
        applyStimulus(1'b1, 32'd11, 32'h0, 1'b1, "drain_end");
        checkOutput("drain_end.empty_lit", 32'(empty), 32'd1);

        // Random phase: slow consumer first to provoke overflow, then a fast one.
        for (int i = 0; i < 400; i++) begin
            logic        rEn;
            logic        rReady;
            logic [31:0] rRes;
            rEn    = ($urandom_range(0, 3) != 0);
            rRes   = 32'($urandom_range(0, 5));
            rReady = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(rEn, rRes, $urandom, rReady, "random");
        end
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, "random_drain");

        for (int v = 21; v <= 25; v++) applyStimulus(1'b1, 32'(v), 32'h200 + 32'(v), 1'b0, "prefill");
        checkOutput("prefill.level_lit", 32'(level), 32'd5);

        // Asynchronous reset mid-cycle: outputs must clear without any clock edge.
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        compareAll("async_reset");
        checkOutput("async_reset.empty_lit", 32'(empty), 32'd1);
        result = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        applyStimulus(1'b1, 32'd3, 32'h333, 1'b0, "post_reset");
        checkOutput("post_reset.level_lit", 32'(level), 32'd1);
        checkOutput("post_reset.dout_lit", rd_if.dout, 32'd3);
        applyStimulus(1'b1, 32'd3, 32'h0, 1'b1, "post_reset_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
